note_sequencer: RTL and testbench

Melody playback controller that sits directly upstream of `wave_generator`. It walks a note ROM, decodes each entry into a full-wave period (in `clk` cycles) and an enable, and holds them for the encoded duration. Each sounding note ends with a short silence gap for articulation. The `period`/`en` outputs connect straight to `wave_generator`'s `period`/`en` inputs.

---
 rtl/note_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody playback controller: walks a note ROM, decodes each entry into a
// wave period plus enable for wave_generator, and times notes, gaps and rests.
module note_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TICK_CLKS = 12_500_000,
    parameter int unsigned GAP_CLKS  = 1_000_000,
    parameter int unsigned LOOP      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [31:0]       period,
    output logic              en,
    output logic              playing,
    output logic              done
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DUR_W = 8;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_CLKS - 1);
    localparam logic [CNT_W-1:0]  PLAY_LAST = CNT_W'(TICK_CLKS - GAP_CLKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef struct packed {
        logic [3:0]       octave;
        logic [3:0]       semitone;
        logic [DUR_W-1:0] dur;
    } note_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_REST
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic [31:0]       period_nxt;
    logic              en_nxt, playing_nxt, done_nxt;
    logic [CNT_W-1:0]  clk_cnt, clk_cnt_nxt;
    logic [DUR_W-1:0]  tick_cnt, tick_cnt_nxt;
    logic [DUR_W-1:0]  dur, dur_nxt;

    note_word_t        word;
    logic              is_rest;
    logic [31:0]       note_period;
    logic              tick_end, last_tick, play_end, note_end;
    logic              advance, song_end;

    // Octave-0 full-wave periods at 100 MHz, C..B
    function automatic logic [31:0] base_period(input logic [3:0] semi);
        case (semi)
            4'd0:    base_period = 32'd6_115_610;
            4'd1:    base_period = 32'd5_772_375;
            4'd2:    base_period = 32'd5_448_402;
            4'd3:    base_period = 32'd5_142_604;
            4'd4:    base_period = 32'd4_853_968;
            4'd5:    base_period = 32'd4_581_524;
            4'd6:    base_period = 32'd4_324_378;
            4'd7:    base_period = 32'd4_081_683;
            4'd8:    base_period = 32'd3_852_600;
            4'd9:    base_period = 32'd3_636_364;
            4'd10:   base_period = 32'd3_432_274;
            4'd11:   base_period = 32'd3_239_633;
            default: base_period = 32'd0;
        endcase
    endfunction

    assign word        = note_word_t'(rom_data);
    assign is_rest     = (word.semitone > 4'd11) || (word.octave > 4'd8);
    assign note_period = base_period(word.semitone) >> word.octave;

    // Duration runs as ticks of TICK_CLKS clocks; the gap is the tail of the last tick
    assign tick_end  = (clk_cnt == TICK_LAST);
    assign last_tick = (tick_cnt == dur - DUR_W'(1));
    assign play_end  = last_tick && (clk_cnt == PLAY_LAST);
    assign note_end  = last_tick && tick_end;

    always_comb begin
        state_nxt    = state;
        rom_addr_nxt = rom_addr;
        period_nxt   = period;
        en_nxt       = en;
        playing_nxt  = playing;
        done_nxt     = 1'b0;
        clk_cnt_nxt  = clk_cnt;
        tick_cnt_nxt = tick_cnt;
        dur_nxt      = dur;
        advance      = 1'b0;
        song_end     = 1'b0;

        if (state inside {S_PLAY, S_GAP, S_REST}) begin
            if (tick_end) begin
                clk_cnt_nxt  = '0;
                tick_cnt_nxt = tick_cnt + DUR_W'(1);
            end else begin
                clk_cnt_nxt  = clk_cnt + CNT_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_FETCH;
                    rom_addr_nxt = '0;
                    playing_nxt  = 1'b1;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                dur_nxt      = word.dur;
                clk_cnt_nxt  = '0;
                tick_cnt_nxt = '0;
                if (word.dur == '0) begin
                    song_end = 1'b1;
                end else if (is_rest) begin
                    state_nxt = S_REST;
                end else begin
                    state_nxt  = S_PLAY;
                    period_nxt = note_period;
                    en_nxt     = 1'b1;
                end
            end
            S_PLAY: begin
                if (play_end) begin
                    state_nxt = S_GAP;
                    en_nxt    = 1'b0;
                end
            end
            S_GAP, S_REST: advance = note_end;
            default: state_nxt = S_IDLE;
        endcase

        // The last ROM address never wraps silently; it ends the song
        if (advance) begin
            if (rom_addr == ADDR_LAST) begin
                song_end = 1'b1;
            end else begin
                rom_addr_nxt = rom_addr + ADDR_W'(1);
                state_nxt    = S_FETCH;
            end
        end

        if (song_end) begin
            en_nxt = 1'b0;
            if (LOOP != 0) begin
                rom_addr_nxt = '0;
                state_nxt    = S_FETCH;
            end else begin
                state_nxt   = S_IDLE;
                playing_nxt = 1'b0;
                done_nxt    = 1'b1;
            end
        end

        if (stop) begin
            state_nxt   = S_IDLE;
            en_nxt      = 1'b0;
            playing_nxt = 1'b0;
            done_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            period   <= '0;
            en       <= 1'b0;
            playing  <= 1'b0;
            done     <= 1'b0;
            clk_cnt  <= '0;
            tick_cnt <= '0;
            dur      <= '0;
        end else begin
            state    <= state_nxt;
            rom_addr <= rom_addr_nxt;
            period   <= period_nxt;
            en       <= en_nxt;
            playing  <= playing_nxt;
            done     <= done_nxt;
            clk_cnt  <= clk_cnt_nxt;
            tick_cnt <= tick_cnt_nxt;
            dur      <= dur_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: one non-looping and one looping instance,
// expected tone/done events computed from the ROM contents by a timeline model.
`timescale 1ns/1ps
module tb_note_sequencer;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned TICK   = 10;
    localparam int unsigned GAP    = 2;
    localparam logic [1:0]  EV_NOTE = 2'd1;
    localparam logic [1:0]  EV_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        inst;
        logic [31:0] cyc;
        logic [31:0] len;
        logic [31:0] per;
    } ev_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             start_v, stop_v, en_v, playing_v, done_v;
    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][15:0]       rdata_v;
    logic [1:0][31:0]       per_v;

    logic [15:0] rom [2][4];
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    logic [31:0] last_per [2];
    int unsigned base_tbl [12] = '{6115610, 5772375, 5448402, 5142604, 4853968, 4581524,
                                   4324378, 4081683, 3852600, 3636364, 3432274, 3239633};

    note_sequencer #(.ADDR_W(ADDR_W), .TICK_CLKS(TICK), .GAP_CLKS(GAP), .LOOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
        .rom_addr(addr_v[0]), .rom_data(rdata_v[0]), .period(per_v[0]),
        .en(en_v[0]), .playing(playing_v[0]), .done(done_v[0]));

    note_sequencer #(.ADDR_W(ADDR_W), .TICK_CLKS(TICK), .GAP_CLKS(GAP), .LOOP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
        .rom_addr(addr_v[1]), .rom_data(rdata_v[1]), .period(per_v[1]),
        .en(en_v[1]), .playing(playing_v[1]), .done(done_v[1]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 32'd1;
        rdata_v[0] <= rom[0][addr_v[0]];
        rdata_v[1] <= rom[1][addr_v[1]];
    end

    function automatic ev_t mk_ev(input logic [1:0] kind, input int inst, input logic [31:0] c,
                                  input logic [31:0] len, input logic [31:0] per);
        ev_t e;
        e.kind = kind;
        e.inst = 1'(inst);
        e.cyc  = c;
        e.len  = len;
        e.per  = per;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic observe(input ev_t o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d inst=%0d cyc=%0d len=%0d period=%0d",
                     o.kind, o.inst, o.cyc, o.len, o.per);
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL event got kind=%0d inst=%0d cyc=%0d len=%0d period=%0d required kind=%0d inst=%0d cyc=%0d len=%0d period=%0d",
                         o.kind, o.inst, o.cyc, o.len, o.per, e.kind, e.inst, e.cyc, e.len, e.per);
            end
        end
    endtask

    // Monitor: a tone event is reported when en falls, done is reported when it pulses
    logic [1:0]  prev_en = 2'b00;
    logic [31:0] rise_cyc [2];
    logic [31:0] rise_per [2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_v[i] && !prev_en[i]) begin
                rise_cyc[i] = cyc;
                rise_per[i] = per_v[i];
            end
            if (!en_v[i] && prev_en[i])
                observe(mk_ev(EV_NOTE, i, rise_cyc[i], cyc - rise_cyc[i], rise_per[i]));
            if (done_v[i])
                observe(mk_ev(EV_DONE, i, cyc, {30'd0, playing_v[i], en_v[i]}, per_v[i]));
            prev_en[i] = en_v[i];
        end
    end

    // Timeline model: FETCH edge t, decode edge t+2, slot of dur*TICK after decode
    task automatic model(input int inst, input logic [31:0] e0, input logic [31:0] s_edge,
                         output logic [31:0] end_edge, output logic nat_end,
                         output logic [1:0] fin_addr);
        logic [31:0] t, ld, nxt, f, p;
        logic [15:0] w;
        int          a, o, sm, d;
        bit          fin, eos;
        t = e0; a = 0; fin = 0;
        end_edge = s_edge; nat_end = 1'b0; fin_addr = 2'd0;
        while (!fin) begin
            if (t >= s_edge) break;
            w  = rom[inst][a];
            o  = int'(w[15:12]);
            sm = int'(w[11:8]);
            d  = int'(w[7:0]);
            ld = t + 32'd2;
            if (ld >= s_edge) break;
            eos = 0;
            if (d == 0) begin
                eos = 1;
                t   = ld;
            end else begin
                nxt = ld + 32'(d) * TICK;
                if (sm < 12 && o < 9) begin
                    p = base_tbl[sm] >> o;
                    last_per[inst] = p;
                    f = nxt - GAP;
                    if (f > s_edge) f = s_edge;
                    exp_q.push_back(mk_ev(EV_NOTE, inst, ld, f - ld, p));
                end
                if (nxt >= s_edge) break;
                t = nxt;
                if (a == 3) eos = 1;
                else a++;
            end
            if (eos) begin
                if (inst == 1) begin
                    a = 0;
                end else begin
                    exp_q.push_back(mk_ev(EV_DONE, inst, t, 32'd0, last_per[inst]));
                    end_edge = t;
                    nat_end  = 1'b1;
                    fin_addr = 2'(a);
                    fin      = 1;
                end
            end
        end
    endtask

    task automatic run(input int inst, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3, input int stop_after);
        logic [31:0] e0, s_edge, end_edge;
        logic        nat_end;
        logic [1:0]  fin_addr;
        @(negedge clk);
        rom[inst][0] = w0; rom[inst][1] = w1; rom[inst][2] = w2; rom[inst][3] = w3;
        e0     = cyc + 32'd1;
        s_edge = (stop_after > 0) ? e0 + 32'(stop_after) : 32'hFFFF_0000;
        model(inst, e0, s_edge, end_edge, nat_end, fin_addr);
        start_v[inst] = 1'b1;
        while (cyc < end_edge + 32'd3 && cyc < e0 + 32'd2000) begin
            @(negedge clk);
            start_v[inst] = 1'b0;
            stop_v[inst]  = 1'b0;
            if (cyc + 32'd1 == s_edge && s_edge <= end_edge) begin
                stop_v[inst]  = 1'b1;
                start_v[inst] = 1'($urandom_range(1));
            end else if (cyc + 32'd1 <= end_edge && $urandom_range(15) == 0) begin
                start_v[inst] = 1'b1;
            end
        end
        chk("expected_events_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("playing_after_end", {31'd0, playing_v[inst]}, 32'd0);
        chk("en_after_end", {31'd0, en_v[inst]}, 32'd0);
        if (nat_end) chk("rom_addr_at_end", {30'd0, addr_v[inst]}, {30'd0, fin_addr});
    endtask

    function automatic logic [15:0] rnd_word();
        logic [3:0] o, s;
        logic [7:0] d;
        o = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8));
        s = 4'($urandom_range(13));
        d = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        return {o, s, d};
    endfunction

    task automatic start_stop_idle(input int inst);
        @(negedge clk);
        start_v[inst] = 1'b1;
        stop_v[inst]  = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        stop_v[inst]  = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_stop_playing", {31'd0, playing_v[inst]}, 32'd0);
        chk("start_stop_en", {31'd0, en_v[inst]}, 32'd0);
    endtask

    initial begin
        logic [31:0] e0, end_edge;
        logic        nat_end;
        logic [1:0]  fin_addr;
        int          inst;
        rst_n   = 1'b0;
        start_v = 2'b00;
        stop_v  = 2'b00;
        last_per[0] = 32'd0;
        last_per[1] = 32'd0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) rom[i][j] = 16'h0000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_rom_addr", {30'd0, addr_v[i]}, 32'd0);
            chk("reset_period", per_v[i], 32'd0);
            chk("reset_flags", {28'd0, en_v[i], playing_v[i], done_v[i], 1'b0}, 32'd0);
        end
        rst_n = 1'b1;

        run(0, 16'h4902, 16'h0000, 16'h0000, 16'h0000, 0);
        run(0, 16'h4C03, 16'h8001, 16'h0000, 16'h0000, 0);
        run(0, 16'h4904, 16'h0000, 16'h0000, 16'h0000, 10);
        run(0, 16'h4904, 16'h0000, 16'h0000, 16'h0000, 0);

        // Asynchronous reset in the middle of a tone
        @(negedge clk);
        rom[0][0] = 16'h4904; rom[0][1] = 16'h0000;
        e0 = cyc + 32'd1;
        model(0, e0, e0 + 32'd6, end_edge, nat_end, fin_addr);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_en", {31'd0, en_v[0]}, 32'd0);
        chk("async_reset_playing", {31'd0, playing_v[0]}, 32'd0);
        chk("async_reset_period", per_v[0], 32'd0);
        chk("async_reset_rom_addr", {30'd0, addr_v[0]}, 32'd0);
        last_per[0] = 32'd0;
        last_per[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_events_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("post_reset_idle", {31'd0, playing_v[0]}, 32'd0);

        run(0, 16'h4001, 16'h4101, 16'h4201, 16'h4301, 0);
        run(1, 16'h4001, 16'h4101, 16'h4201, 16'h4301, 200);
        start_stop_idle(0);
        start_stop_idle(1);

        for (int n = 0; n < 40; n++) begin
            inst = int'($urandom_range(1));
            if (inst == 1)
                run(1, rnd_word(), rnd_word(), rnd_word(), rnd_word(), int'($urandom_range(1, 150)));
            else if ($urandom_range(9) < 3)
                run(0, rnd_word(), rnd_word(), rnd_word(), rnd_word(), int'($urandom_range(1, 120)));
            else
                run(0, rnd_word(), rnd_word(), rnd_word(), rnd_word(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
